cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/rv32i_types.sv | 19 +
 rtl/cache_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory arbiter: FSM states, grant owner and
// the default cache line width.
package rv32i_types;

  localparam int LINE_WIDTH_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one line adaptor,
// one transaction at a time, alternating owners under contention.
// Handshake: x_read/x_write are level requests held until the one-cycle x_resp
// pulse; mem_read/mem_write are held with stable addr/data until mem_resp.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [31:0]           i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output arb_state_t            dbg_state,
  output grant_t                dbg_last_grant
);

  arb_state_t            state_q, state_d;
  grant_t                last_grant_q, last_grant_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic serving;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    pick_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // Under contention the dcache wins unless it was the previous owner.
        pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));
        if (pick_d) begin
          state_d = SERVE_D;
          addr_d  = d_addr;
          write_d = d_write;
          wdata_d = d_write ? d_wdata : '0;
        end else if (i_req) begin
          state_d = SERVE_I;
          addr_d  = i_addr;
          write_d = 1'b0;
          wdata_d = '0;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          last_grant_d = GRANT_I;
          state_d      = RELEASE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          last_grant_d = GRANT_D;
          state_d      = RELEASE;
        end
      end
      RELEASE: begin
        // The requester drops its level request this cycle; skipping it here
        // keeps the just-served request from being granted a second time.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  assign serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign mem_read  = serving && !write_q;
  assign mem_write = serving && write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_resp  = (state_q == SERVE_I) && mem_resp;
  assign d_resp  = (state_q == SERVE_D) && mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_cache_arbiter;
  import rv32i_types::*;

  localparam int LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  arb_state_t    dbg_state;
  grant_t        dbg_last_grant;

  int total;
  int bad;

  logic exp_q[$];

  cache_arbiter #(.LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One transaction record: who owns the adaptor, what was captured at grant,
  // and a one-cycle quiet gap after each completion.
  logic          m_active;
  logic          m_owner_d;
  logic [31:0]   m_addr;
  logic          m_write;
  logic [LW-1:0] m_wdata;
  logic          m_gap;
  logic          m_last_d;
  logic          m_any_req;
  logic          m_take_d;

  assign m_any_req = i_read | d_read | d_write;
  assign m_take_d  = (d_read | d_write) && !(i_read && m_last_d);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active  <= 1'b0;
      m_owner_d <= 1'b0;
      m_addr    <= '0;
      m_write   <= 1'b0;
      m_wdata   <= '0;
      m_gap     <= 1'b0;
      m_last_d  <= 1'b0;
    end else if (m_active) begin
      if (mem_resp) begin
        m_active <= 1'b0;
        m_last_d <= m_owner_d;
        m_gap    <= 1'b1;
      end
    end else if (m_gap) begin
      m_gap <= 1'b0;
    end else if (m_any_req) begin
      m_active  <= 1'b1;
      m_owner_d <= m_take_d;
      m_addr    <= m_take_d ? d_addr : i_addr;
      m_write   <= m_take_d && d_write;
      m_wdata   <= d_wdata;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic          e_ir, e_dr;
    logic [1:0]    e_state;
    e_ir = m_active && !m_owner_d && mem_resp;
    e_dr = m_active && m_owner_d && mem_resp;
    if (m_active)   e_state = m_owner_d ? 2'd2 : 2'd1;
    else if (m_gap) e_state = 2'd3;
    else            e_state = 2'd0;
    chk("cyc_state", LW'(dbg_state), LW'(e_state));
    chk("cyc_mem_read", LW'(mem_read), LW'(m_active && !m_write));
    chk("cyc_mem_write", LW'(mem_write), LW'(m_active && m_write));
    chk("cyc_i_resp", LW'(i_resp), LW'(e_ir));
    chk("cyc_d_resp", LW'(d_resp), LW'(e_dr));
    chk("cyc_i_rdata", i_rdata, e_ir ? mem_rdata : '0);
    chk("cyc_d_rdata", d_rdata, e_dr ? mem_rdata : '0);
    if (m_active) chk("cyc_mem_addr", LW'(mem_addr), LW'(m_addr));
    if (m_active && m_write) chk("cyc_mem_wdata", mem_wdata, m_wdata);
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [LW-1:0] line_aa;
    logic [LW-1:0] line_12;
    logic [LW-1:0] rd;
    logic          got;
    int            budget;
    int            mem_cnt;
    logic          gi, gd, mreq;
    int            k;

    total = 0;
    bad   = 0;
    line_aa = {(LW / 8){8'hAA}};
    line_12 = {(LW / 32){32'h1234_5678}};

    rst = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) tick();
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_write", LW'(mem_write), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_state", LW'(dbg_state), LW'(2'd0));
    rst = 1'b1;
    tick();

    // Single icache fill, 5-cycle adaptor latency.
    i_read = 1'b1; i_addr = 32'h0000_0060;
    tick(); settle();
    chk("fill_mem_read_c1", LW'(mem_read), LW'(1'b1));
    chk("fill_mem_addr_c1", LW'(mem_addr), LW'(32'h60));
    for (int c = 0; c < 4; c++) begin
      chk("fill_no_resp_early", LW'(i_resp), '0);
      tick();
    end
    mem_resp = 1'b1; mem_rdata = line_aa; settle();
    chk("fill_i_resp", LW'(i_resp), LW'(1'b1));
    chk("fill_i_rdata", i_rdata, line_aa);
    chk("fill_d_resp_quiet", LW'(d_resp), '0);
    tick();
    mem_resp = 1'b0; i_read = 1'b0; settle();
    chk("fill_release_idle_mem", LW'({mem_read, mem_write}), '0);
    chk("fill_release_no_resp", LW'(i_resp), '0);
    tick();

    // Simultaneous requests after an icache grant: dcache first, then icache.
    i_read = 1'b1; i_addr = 32'h400; d_read = 1'b1; d_addr = 32'h300;
    tick(); settle();
    chk("cont_first_d", LW'(dbg_state), LW'(2'd2));
    chk("cont_first_addr", LW'(mem_addr), LW'(32'h300));
    rd = rand_line();
    mem_resp = 1'b1; mem_rdata = rd; settle();
    chk("cont_d_resp", LW'(d_resp), LW'(1'b1));
    chk("cont_d_rdata", d_rdata, rd);
    chk("cont_i_rdata_zero", i_rdata, '0);
    tick();
    mem_resp = 1'b0; d_read = 1'b0;
    tick();
    tick(); settle();
    chk("cont_then_i", LW'(dbg_state), LW'(2'd1));
    chk("cont_then_i_addr", LW'(mem_addr), LW'(32'h400));
    mem_resp = 1'b1; settle();
    chk("cont_i_resp", LW'(i_resp), LW'(1'b1));
    tick();
    mem_resp = 1'b0; i_read = 1'b0;
    tick();

    // Both held for four transactions: D, I, D, I.
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    i_read = 1'b1; d_read = 1'b1;
    for (int n = 0; n < 4; n++) begin
      budget = 0;
      while (!(dbg_state == SERVE_I || dbg_state == SERVE_D) && budget < 10) begin
        tick();
        budget++;
      end
      if (budget >= 10) begin
        total++; bad++;
        $display("FAIL alt_grant_timeout n=%0d", n);
      end else begin
        got = (dbg_state == SERVE_D);
        chk("alt_order", LW'(got), LW'(exp_q.pop_front()));
      end
      mem_resp = 1'b1;
      tick();
      mem_resp = 1'b0;
    end
    i_read = 1'b0; d_read = 1'b0;
    tick(); tick();

    // Writeback with addr/data changing mid-transaction.
    d_write = 1'b1; d_addr = 32'h100; d_wdata = line_12;
    tick();
    d_addr = 32'h200; d_wdata = rand_line();
    tick(); settle();
    chk("wb_mem_write", LW'(mem_write), LW'(1'b1));
    chk("wb_mem_read", LW'(mem_read), '0);
    chk("wb_mem_addr", LW'(mem_addr), LW'(32'h100));
    chk("wb_mem_wdata", mem_wdata, line_12);
    mem_resp = 1'b1; settle();
    chk("wb_d_resp", LW'(d_resp), LW'(1'b1));
    tick();
    mem_resp = 1'b0; d_write = 1'b0;
    tick();

    // Reset during a dcache fill; late adaptor response is dropped.
    d_read = 1'b1; d_addr = 32'h500;
    tick(); tick();
    rst = 1'b0; settle();
    chk("abort_state", LW'(dbg_state), LW'(2'd0));
    chk("abort_mem", LW'({mem_read, mem_write}), '0);
    chk("abort_mem_addr", LW'(mem_addr), '0);
    d_read = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    mem_resp = 1'b1; mem_rdata = rand_line(); settle();
    chk("late_d_resp", LW'(d_resp), '0);
    chk("late_i_resp", LW'(i_resp), '0);
    chk("late_mem", LW'({mem_read, mem_write}), '0);
    tick();
    mem_resp = 1'b0; settle();
    chk("late_state", LW'(dbg_state), LW'(2'd0));

    // Spurious adaptor response while idle.
    tick();
    mem_resp = 1'b1; mem_rdata = line_aa; settle();
    chk("spur_i_resp", LW'(i_resp), '0);
    chk("spur_d_rdata", d_rdata, '0);
    tick();
    mem_resp = 1'b0; settle();
    chk("spur_state", LW'(dbg_state), LW'(2'd0));

    // Randomized traffic, checked every cycle by the model.
    mem_cnt = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      gi = i_resp; gd = d_resp; mreq = mem_read | mem_write;
      tick();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst = 1'b0;
      if (gi) i_read = 1'b0;
      else if (!i_read) i_read = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 40) == 0) i_read = 1'b0;
      i_addr = $urandom;
      if (gd) begin
        d_read = 1'b0; d_write = 1'b0;
      end else if (!(d_read || d_write)) begin
        k = $urandom_range(0, 5);
        d_read  = (k == 1) || (k == 3);
        d_write = (k == 2) || (k == 3);
      end else if ($urandom_range(0, 40) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
      d_addr  = $urandom;
      d_wdata = rand_line();
      if (mem_resp) begin
        mem_resp = 1'b0;
        mem_cnt  = -1;
      end else if (mreq) begin
        if (mem_cnt < 0) mem_cnt = $urandom_range(0, 4);
        if (mem_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = rand_line();
        end else begin
          mem_cnt--;
        end
      end else if ($urandom_range(0, 30) == 0) begin
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
      end
    end

    rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
